// File: rtl/arm_hazard_pkg.sv
// Shared types and defaults for the ARM pipeline hazard unit.
package arm_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam int PC_IDX      = 15;
    localparam int DEF_NREG    = 16;
    localparam int DEF_NSRC    = 3;
    localparam int DEF_MAX_LAT = 4;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register result-latency scoreboard: one down-counter per architectural
// register (PC excluded), producing RAW and WAW hazard flags for Decode.
module hazard_scoreboard
    import arm_hazard_pkg::*;
#(
    parameter int NREG    = DEF_NREG,
    parameter int NSRC    = DEF_NSRC,
    parameter int MAX_LAT = DEF_MAX_LAT,
    localparam int RW     = $clog2(NREG),
    localparam int LW     = $clog2(MAX_LAT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC*RW-1:0] ra_d,
    input  logic [NSRC-1:0]    rvld_d,
    input  logic [RW-1:0]      wa_d,
    input  logic               we_d,
    input  logic [LW-1:0]      lat_d,
    input  logic               issue_ok,
    output logic               raw,
    output logic               waw
);

    logic [LW-1:0] cnt_q [NREG-1];
    logic [LW-1:0] cnt_d [NREG-1];
    logic [NREG-1:0] busy;
    logic issue;

    assign issue = we_d & issue_ok & (wa_d != RW'(PC_IDX));

    // The issued entry reloads instead of decrementing; idle entries hold at 0.
    always_comb begin
        for (int r = 0; r < NREG - 1; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && wa_d == RW'(r)) begin
                cnt_d[r] = lat_d;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG - 1; r++) begin
            if (reset) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // The PC slot is permanently idle so it can never raise a hazard.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == PC_IDX || gi >= NREG - 1) begin : g_pc
                assign busy[gi] = 1'b0;
            end else begin : g_reg
                assign busy[gi] = (cnt_q[gi] != '0);
            end
        end
    endgenerate

    always_comb begin
        raw = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (rvld_d[s] && busy[ra_d[s*RW +: RW]]) begin
                raw = 1'b1;
            end
        end
    end

    assign waw = we_d & busy[wa_d];

endmodule

// File: rtl/arm_hazard_scoreboard.sv
// Hazard unit for the 5-stage ARM pipeline: scoreboard stalls, forwarding,
// PC-write/branch flushes. Define HAZARD_STATS_EN to enable stall/flush counters.
module arm_hazard_scoreboard
    import arm_hazard_pkg::*;
#(
    parameter int NREG    = DEF_NREG,
    parameter int NSRC    = DEF_NSRC,
    parameter int MAX_LAT = DEF_MAX_LAT,
    localparam int RW     = $clog2(NREG),
    localparam int LW     = $clog2(MAX_LAT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*RW-1:0]   ra_d,
    input  logic [NSRC-1:0]      rvld_d,
    input  logic [RW-1:0]        wa_d,
    input  logic                 we_d,
    input  logic [LW-1:0]        lat_d,
    input  logic [NSRC*RW-1:0]   ra_e,
    input  logic [RW-1:0]        wa_m,
    input  logic                 regwrite_m,
    input  logic [RW-1:0]        wa_w,
    input  logic                 regwrite_w,
    input  logic                 pcsrc_d,
    input  logic                 pcsrc_e,
    input  logic                 pcsrc_m,
    input  logic                 pcsrc_w,
    input  logic                 branchtaken_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [NSRC*2-1:0]    fwd_e,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
);

    logic raw, waw, pcwr;
    logic stall_d_int, flush_e_int;

    assign pcwr        = pcsrc_d | pcsrc_e | pcsrc_m;
    assign stall_d_int = (raw | waw) & ~branchtaken_e;
    assign flush_e_int = stall_d_int | branchtaken_e;

    hazard_scoreboard #(
        .NREG    (NREG),
        .NSRC    (NSRC),
        .MAX_LAT (MAX_LAT)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .ra_d     (ra_d),
        .rvld_d   (rvld_d),
        .wa_d     (wa_d),
        .we_d     (we_d),
        .lat_d    (lat_d),
        .issue_ok (~stall_d_int & ~flush_e_int),
        .raw      (raw),
        .waw      (waw)
    );

    // Reset holds the pipeline in a flushed, non-stalled state.
    assign stall_d = ~reset & stall_d_int;
    assign stall_f = ~reset & (stall_d_int | pcwr);
    assign flush_e = reset | flush_e_int;
    assign flush_d = reset | pcwr | pcsrc_w | branchtaken_e;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_fwd
            fwd_sel_t sel;
            logic [RW-1:0] src;
            assign src = ra_e[gi*RW +: RW];
            // M holds the younger result, so it wins over W.
            always_comb begin
                sel = FWD_RF;
                if (!reset && src != RW'(PC_IDX)) begin
                    if (regwrite_m && wa_m == src) begin
                        sel = FWD_M;
                    end else if (regwrite_w && wa_w == src) begin
                        sel = FWD_W;
                    end
                end
            end
            assign fwd_e[gi*2 +: 2] = sel;
        end
    endgenerate

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_d_int && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_e_int && !stall_d_int && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Randomized and directed checks of arm_hazard_scoreboard against a
// cycle-level reference model of the hazard rules.
module tb_arm_hazard_scoreboard;
    import arm_hazard_pkg::*;

    localparam int NREG = 16, NSRC = 3, MAX_LAT = 4, RW = 4, LW = 3;

    logic clk = 1'b0;
    logic reset;
    logic [NSRC*RW-1:0] ra_d, ra_e;
    logic [NSRC-1:0] rvld_d;
    logic [RW-1:0] wa_d, wa_m, wa_w;
    logic we_d, regwrite_m, regwrite_w;
    logic [LW-1:0] lat_d;
    logic pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branchtaken_e;
    logic stall_f, stall_d, flush_d, flush_e;
    logic [NSRC*2-1:0] fwd_e;
    logic [31:0] stall_cnt, flush_cnt;

    arm_hazard_scoreboard dut (
        .clk(clk), .reset(reset), .ra_d(ra_d), .rvld_d(rvld_d), .wa_d(wa_d),
        .we_d(we_d), .lat_d(lat_d), .ra_e(ra_e), .wa_m(wa_m),
        .regwrite_m(regwrite_m), .wa_w(wa_w), .regwrite_w(regwrite_w),
        .pcsrc_d(pcsrc_d), .pcsrc_e(pcsrc_e), .pcsrc_m(pcsrc_m),
        .pcsrc_w(pcsrc_w), .branchtaken_e(branchtaken_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .flush_e(flush_e), .fwd_e(fwd_e), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int busy_left [NREG];   // remaining busy cycles per register
    int n_vec = 0, n_miss = 0, cyc = 0;
    logic [31:0] m_stall_cnt = 0, m_flush_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        reset = 0; ra_d = '0; ra_e = '0; rvld_d = '0; wa_d = '0; we_d = 0;
        lat_d = '0; wa_m = '0; wa_w = '0; regwrite_m = 0; regwrite_w = 0;
        pcsrc_d = 0; pcsrc_e = 0; pcsrc_m = 0; pcsrc_w = 0; branchtaken_e = 0;
    endtask

    // Check every output against the model at negedge, then advance the model at posedge.
    task automatic cycle();
        bit raw, waw, pcwr, e_sd, e_sf, e_fd, e_fe, iss;
        logic [NSRC*2-1:0] e_fw;
        logic [RW-1:0] r;
        @(negedge clk);
        raw = 0;
        for (int s = 0; s < NSRC; s++) begin
            r = ra_d[s*RW +: RW];
            if (rvld_d[s] && r != 15 && busy_left[r] > 0) raw = 1;
        end
        waw  = we_d && wa_d != 15 && busy_left[wa_d] > 0;
        pcwr = pcsrc_d || pcsrc_e || pcsrc_m;
        e_fw = '0;
        if (reset) begin
            e_sd = 0; e_sf = 0; e_fd = 1; e_fe = 1;
        end else begin
            e_sd = (raw || waw) && !branchtaken_e;
            e_sf = e_sd || pcwr;
            e_fe = e_sd || branchtaken_e;
            e_fd = pcwr || pcsrc_w || branchtaken_e;
            for (int s = 0; s < NSRC; s++) begin
                r = ra_e[s*RW +: RW];
                if (r != 15) begin
                    if (regwrite_m && wa_m == r)      e_fw[s*2 +: 2] = 2'b10;
                    else if (regwrite_w && wa_w == r) e_fw[s*2 +: 2] = 2'b01;
                end
            end
        end
        check("stall_d", 32'(stall_d), 32'(e_sd));
        check("stall_f", 32'(stall_f), 32'(e_sf));
        check("flush_d", 32'(flush_d), 32'(e_fd));
        check("flush_e", 32'(flush_e), 32'(e_fe));
        check("fwd_e", 32'(fwd_e), 32'(e_fw));
`ifdef HAZARD_STATS_EN
        check("stall_cnt", stall_cnt, m_stall_cnt);
        check("flush_cnt", flush_cnt, m_flush_cnt);
`else
        check("stall_cnt", stall_cnt, 32'd0);
        check("flush_cnt", flush_cnt, 32'd0);
`endif
        $display("cyc %0d rst=%b we=%b wa=%0d lat=%0d sd=%b sf=%b fd=%b fe=%b fwd=%h",
                 cyc, reset, we_d, wa_d, lat_d, stall_d, stall_f, flush_d, flush_e, fwd_e);
        iss = !reset && we_d && !e_sd && !e_fe && wa_d != 15;
        @(posedge clk);
        for (int k = 0; k < NREG; k++) begin
            if (reset) busy_left[k] = 0;
            else if (iss && wa_d == k) busy_left[k] = int'(lat_d);
            else if (busy_left[k] > 0) busy_left[k]--;
        end
        if (reset) begin
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (e_sd && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (e_fe && !e_sd && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        end
        cyc++;
        #1;
    endtask

    function automatic logic [RW-1:0] rnd_reg();
        if ($urandom_range(0, 9) == 0) return 4'd15;
        return RW'($urandom_range(0, 7));
    endfunction

    initial begin
        foreach (busy_left[k]) busy_left[k] = 0;
        idle();
        reset = 1;
        #1;
        check("rst_flush_d", 32'(flush_d), 32'd1);
        check("rst_flush_e", 32'(flush_e), 32'd1);
        check("rst_stall_f", 32'(stall_f), 32'd0);
        cycle(); cycle();
        idle();

        // Load then dependent use: one stall cycle, then W forwarding.
        we_d = 1; wa_d = 4'd1; lat_d = 3'd1;
        cycle();
        idle(); ra_d[3:0] = 4'd1; rvld_d = 3'b001;
        #1 check("ldr_stall_d", 32'(stall_d), 32'd1);
        check("ldr_flush_e", 32'(flush_e), 32'd1);
        cycle();
        #1 check("ldr_release", 32'(stall_d), 32'd0);
        cycle();
        idle(); ra_e[3:0] = 4'd1; regwrite_w = 1; wa_w = 4'd1;
        #1 check("ldr_fwd_w", 32'(fwd_e[1:0]), 32'd1);
        cycle();

        // M beats W.
        idle(); ra_e[3:0] = 4'd3; regwrite_m = 1; wa_m = 4'd3; regwrite_w = 1; wa_w = 4'd3;
        #1 check("prio_m", 32'(fwd_e[1:0]), 32'd2);
        cycle();
        regwrite_m = 0;
        #1 check("prio_w", 32'(fwd_e[1:0]), 32'd1);
        cycle();

        // Multi-cycle producer, RAW on operand 2 then WAW.
        for (int pass = 0; pass < 2; pass++) begin
            idle(); we_d = 1; wa_d = 4'd4; lat_d = 3'd3;
            cycle();
            idle();
            if (pass == 0) begin ra_d[11:8] = 4'd4; rvld_d = 3'b100; end
            else begin we_d = 1; wa_d = 4'd4; end
            for (int i = 0; i < 3; i++) begin
                #1 check("mul_stall", 32'(stall_d), 32'd1);
                cycle();
            end
            #1 check("mul_release", 32'(stall_d), 32'd0);
            cycle();
        end

        // Branch overrides a RAW stall; counter keeps decrementing.
        idle(); we_d = 1; wa_d = 4'd5; lat_d = 3'd2;
        cycle();
        idle(); ra_d[3:0] = 4'd5; rvld_d = 3'b001; branchtaken_e = 1;
        #1 check("br_stall_d", 32'(stall_d), 32'd0);
        check("br_flush_d", 32'(flush_d), 32'd1);
        cycle();
        branchtaken_e = 0;
        #1 check("br_residual", 32'(stall_d), 32'd1);
        cycle();
        #1 check("br_done", 32'(stall_d), 32'd0);
        cycle();

        // R15 never stalls or forwards; PC write stalls fetch.
        idle(); we_d = 1; wa_d = 4'd6; lat_d = 3'd3;
        cycle();
        idle(); ra_d[3:0] = 4'd15; rvld_d = 3'b001; ra_e[3:0] = 4'd15;
        regwrite_m = 1; wa_m = 4'd15;
        #1 check("r15_stall", 32'(stall_d), 32'd0);
        check("r15_fwd", 32'(fwd_e[1:0]), 32'd0);
        cycle();
        idle(); pcsrc_e = 1;
        #1 check("pc_stall_f", 32'(stall_f), 32'd1);
        check("pc_flush_d", 32'(flush_d), 32'd1);
        cycle();
        idle(); cycle(); cycle();

        // Reset mid-stall.
        we_d = 1; wa_d = 4'd4; lat_d = 3'd3;
        cycle();
        idle(); ra_d[3:0] = 4'd4; rvld_d = 3'b001;
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        #1 check("post_rst_stall", 32'(stall_d), 32'd0);
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int s = 0; s < NSRC; s++) begin
                ra_d[s*RW +: RW] = rnd_reg();
                ra_e[s*RW +: RW] = rnd_reg();
            end
            rvld_d = NSRC'($urandom_range(0, 7));
            wa_d = rnd_reg(); we_d = $urandom_range(0, 1) == 1;
            lat_d = LW'($urandom_range(0, MAX_LAT));
            wa_m = rnd_reg(); regwrite_m = $urandom_range(0, 1) == 1;
            wa_w = rnd_reg(); regwrite_w = $urandom_range(0, 1) == 1;
            pcsrc_d = $urandom_range(0, 15) == 0;
            pcsrc_e = $urandom_range(0, 15) == 0;
            pcsrc_m = $urandom_range(0, 15) == 0;
            pcsrc_w = $urandom_range(0, 15) == 0;
            branchtaken_e = $urandom_range(0, 11) == 0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/arm_hazard_scoreboard.md
# arm_hazard_scoreboard

Parametrised hazard unit for the 5-stage ARM pipeline (F/D/E/M/W). It generalises forwarding to NSRC source operands and replaces single-cycle load-use detection with a per-register scoreboard of down-counters, so loads and long-latency units (iterative multiplier) stall Decode exactly as long as needed. It also produces PC-write and branch stalls and flushes, and sits between the controller and datapath in `arm`.

## Interface
- NREG, 16, architectural registers; index 15 is the PC.
- NSRC, 3, source operands per instruction (Rn, Rm, Rs).
- MAX_LAT, 4, largest result latency accepted on `lat_d`.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset; one clock domain.
- ra_d  in  NSRC×log2(NREG)  Decode source registers.
- rvld_d  in  NSRC  Decode source valid.
- wa_d  in  log2(NREG)  Decode destination.
- we_d  in  1  Decode instruction writes a register.
- lat_d  in  clog2(MAX_LAT+1)  busy cycles: 0 = ALU, 1 = load, 2..MAX_LAT = multi-cycle.
- ra_e  in  NSRC×log2(NREG)  Execute source registers.
- wa_m, regwrite_m  in  4/1  Memory-stage write.
- wa_w, regwrite_w  in  4/1  Writeback-stage write.
- pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  in  1 each  PC-write in flight.
- branchtaken_e  in  1  branch resolved taken in E.
- stall_f, stall_d, flush_d, flush_e  out  1 each.
- fwd_e  out  NSRC×2  per-operand select: 00 register file, 01 W result, 10 M result.
- stall_cnt, flush_cnt  out  32 each  statistics (see Configuration).

## Operation
- Scoreboard: cnt[r], r = 0..NREG-2, width clog2(MAX_LAT+1). R15 has no entry: it never stalls and never forwards.
- issue = we_d & ~stall_d & ~flush_e & (wa_d != 15). On issue, cnt[wa_d] <= lat_d.
- Every other nonzero cnt decrements by 1 each cycle. The issued entry loads `lat_d` and does not also decrement.
- Counters saturate at 0.
- raw = OR over s of (rvld_d[s] & ra_d[s] != 15 & cnt[ra_d[s]] != 0).
- waw = we_d & wa_d != 15 & cnt[wa_d] != 0. A live counter is never overwritten.
- pcwr = pcsrc_d | pcsrc_e | pcsrc_m.
- stall_d = (raw | waw) & ~branchtaken_e.
- stall_f = stall_d | pcwr.
- flush_e = stall_d | branchtaken_e.
- flush_d = pcwr | pcsrc_w | branchtaken_e.
- Forwarding per operand s, with ra_e[s] != 15:
  - 10 if regwrite_m & wa_m == ra_e[s];
  - else 01 if regwrite_w & wa_w == ra_e[s];
  - else 00.
  - M beats W.
- A long-latency result is forwardable via M/W in the cycle its counter reaches 0.

## Timing
- stall_*, flush_*, fwd_e: combinational from inputs and registered cnt; no added latency.
- Scoreboard updates on rising clk.
- Stall lengths:
  - Load followed by a dependent instruction: stall_d asserted exactly 1 cycle.
  - lat_d = L followed by a dependent instruction: stall_d asserted exactly L cycles.
- Reset:
  - All cnt cleared at the reset edge.
  - stall_cnt and flush_cnt cleared.
  - While reset is high, flush_d = flush_e = 1, stall_f = stall_d = 0, fwd_e = 0.
- Reset asserted mid-stall: the stall ends on the next cycle after reset is released.
- Simultaneous events:
  - branchtaken_e overrides scoreboard stall.
  - A flushed Decode instruction never sets the scoreboard.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cnt increments every cycle stall_d = 1.
  - flush_cnt increments every cycle flush_e & ~stall_d.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and clear on reset.
- HAZARD_STATS_EN undefined: both ports tied to 0 and no counter logic.

## Structure
- Package `arm_hazard_pkg` holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - PC_IDX = 15.
  - Default NREG and MAX_LAT.
- One sub-module, `hazard_scoreboard`: owns the cnt array, issue and decrement logic, and produces raw and waw.
- Forwarding and stall/flush equations live in the top module.

## Test plan
- Load then dependent use:
  - Stimulus: issue LDR R1 (lat_d = 1); next cycle Decode reads R1.
  - Response: stall_d = flush_e = stall_f = 1 for exactly 1 cycle. When the consumer reaches E with R1 in W, fwd_e = 01.
- Forwarding priority:
  - Stimulus: R3 written in both M and W; E operand 0 reads R3.
  - Response: fwd_e[0] = 10. With regwrite_m = 0, fwd_e[0] = 01.
- Multi-cycle producer:
  - Stimulus: MUL R4 (lat_d = 3); next Decode reads R4 on operand 2.
  - Response: stall_d = 1 for 3 cycles, then 0.
  - Also: WAW to R4 during the window stalls identically.
- Branch during stall:
  - Stimulus: branchtaken_e = 1 in a cycle with raw = 1.
  - Response: stall_d = 0, flush_d = flush_e = 1; the scoreboard is unchanged except for decrement.
- R15 and PC-write:
  - Stimulus: source R15 while cnt is busy elsewhere → no stall; fwd 00 even if wa_m = 15.
  - Stimulus: pcsrc_e = 1 → stall_f = 1, flush_d = 1.
- Reset mid-operation and statistics:
  - Stimulus: reset while cnt[4] = 3.
  - Response: the next cycle shows no stall.
  - With HAZARD_STATS_EN: 5 stall cycles give stall_cnt = 5, and it returns to 0 after reset.
